mem_stage_lsu: RTL and testbench
================================

// Module: mem_stage_lsu
// PURPOSE
//  Memory stage directly downstream of the execute ALU. Takes the ALU result as a LW/SW word address,
//  or as a plain result for other ops, and drives a req/gnt/rvalid data-memory port.
//  Produces one registered writeback record per accepted instruction.
//  Stalls execute via ex_ready while a memory access is outstanding.
// PARAMETERS
//  DSIZE     32   data/address width (matches `DSIZE in define.v)
//  RSIZE     5    destination register index width
// PORTS
//  clk         in   1      single clock, rising edge
//  rst         in   1      reset, asynchronous, active-low
//  ex_valid    in   1      execute presents an instruction this cycle
//  ex_ready    out  1      stage accepts it (transfer = ex_valid & ex_ready)
//  ex_op       in   7      opcode (`LW, `SW, `R_TYPE, `I_TYPE, `COND_BRANCH from define.v)
//  ex_result   in   DSIZE  ALU out: memory address for LW/SW, else result
//  ex_wdata    in   DSIZE  store data (rs2 value)
//  ex_rd       in   RSIZE  destination register
//  mem_req     out  1      memory request, held until mem_gnt
//  mem_we      out  1      1 = store, 0 = load
//  mem_addr    out  DSIZE  word address, bits [1:0] always 0
//  mem_wdata   out  DSIZE  store data
//  mem_gnt     in   1      request accepted this cycle
//  mem_rvalid  in   1      load data valid (loads only; stores complete at gnt)
//  mem_rdata   in   DSIZE  load data
//  wb_valid    out  1      writeback record valid, one-cycle pulse
//  wb_we       out  1      write register file
//  wb_rd       out  RSIZE  destination register
//  wb_data     out  DSIZE  writeback value
//  misalign    out  1      one-cycle pulse: LW/SW address[1:0] != 0; access suppressed
// BEHAVIOUR
//  Reset (rst=0, async): state=IDLE; ex_ready=1; mem_req=0, mem_we=0, mem_addr=0, mem_wdata=0;
//   wb_valid=0, wb_we=0, wb_rd=0, wb_data=0, misalign=0. All outputs are registered except ex_ready.
//  ex_ready = (state==IDLE), combinational.
//  FSM states: IDLE, REQ, WAIT_RSP.
//  IDLE, transfer of an op that is not LW/SW: next cycle wb_valid=1, wb_data=ex_result, wb_rd=ex_rd.
//   wb_we=1 for R_TYPE/I_TYPE and 0 for COND_BRANCH/unknown. Latency 1. Stay IDLE, back-to-back allowed.
//  IDLE, LW/SW with addr[1:0]!=0: next cycle misalign=1, wb_valid=1, wb_we=0. No memory request. Stay IDLE.
//  IDLE, aligned LW/SW: latch addr/wdata/rd/we; mem_req=1 next cycle; go to REQ.
//  REQ: hold mem_req and all mem_* stable until mem_gnt.
//   On gnt: mem_req=0. SW goes to IDLE with wb_valid=1, wb_we=0 next cycle. LW goes to WAIT_RSP.
//  WAIT_RSP: on mem_rvalid, wb_valid=1, wb_we=1, wb_data=mem_rdata, wb_rd=latched rd next cycle; go to IDLE.
//  Min latency: SW 2 cycles, LW 3 cycles (gnt and rvalid each in the earliest possible cycle).
//  mem_gnt in the same cycle mem_req rises counts. mem_rvalid is only honoured in WAIT_RSP.
//  mem_gnt/mem_rvalid outside REQ/WAIT_RSP: ignored.
//  wb_rd==0 with wb_we=1: record still emitted; the register file discards x0 writes.
//  ex_valid while not IDLE: not accepted, because ex_ready=0; upstream holds its inputs.
//  Reset mid-access: FSM returns to IDLE immediately, mem_req drops, and any in-flight response is ignored.
//  wb_valid and misalign are never high two cycles in a row for the same instruction.
// STRUCTURE
//  Opcode constants and `DSIZE come from the shared define.v. Add a `LSU_IDLE/`LSU_REQ/`LSU_WAIT
//  state encoding (2 bits) there as well.
//  Single flat module; no sub-module needed. Writeback register set kept in one always block.
// TESTING
//  ADD: ex_op=R_TYPE, ex_result=32'h0000_0005, rd=3 -> next cycle wb_valid=1, wb_we=1, wb_rd=3, wb_data=5.
//  SW: addr=32'h10, wdata=32'hDEAD_BEEF, gnt delayed 2 cycles -> mem_req/mem_we=1/mem_addr=32'h10 held 3 cycles;
//   ex_ready=0 throughout; wb_valid=1, wb_we=0 one cycle after gnt.
//  LW: addr=32'h20, gnt immediate, rvalid 3 cycles later with rdata=32'h1234_5678, rd=7
//   -> wb_data=32'h1234_5678, wb_rd=7, wb_we=1.
//  LW addr=32'h22 -> misalign=1 and wb_valid=1 with wb_we=0 next cycle; mem_req never asserted.
//  Reset asserted during WAIT_RSP, then a stray rvalid -> no wb_valid; ex_ready=1 right after reset release.
//  Back-to-back ADDI x3 then BNE -> four consecutive wb_valid pulses; the BNE record has wb_we=0.

Source files
------------

// File: rtl/mem_stage_lsu_pkg.sv
// Shared constants for the memory stage: opcodes, widths and the LSU state encoding.
package mem_stage_lsu_pkg;

   localparam int unsigned LSU_DSIZE = 32;
   localparam int unsigned LSU_RSIZE = 5;
   localparam int unsigned OP_W      = 7;

   localparam logic [OP_W-1:0] OP_LW          = 7'b000_0011;
   localparam logic [OP_W-1:0] OP_SW          = 7'b010_0011;
   localparam logic [OP_W-1:0] OP_R_TYPE      = 7'b011_0011;
   localparam logic [OP_W-1:0] OP_I_TYPE      = 7'b001_0011;
   localparam logic [OP_W-1:0] OP_COND_BRANCH = 7'b110_0011;

   typedef enum logic [1:0] {
      LSU_IDLE = 2'd0,
      LSU_REQ  = 2'd1,
      LSU_WAIT = 2'd2
   } lsu_state_e;

   function automatic logic is_mem_op(input logic [OP_W-1:0] op);
      return (op == OP_LW) || (op == OP_SW);
   endfunction

   // Only ALU ops write the register file; branches and unknown opcodes do not.
   function automatic logic is_rf_write(input logic [OP_W-1:0] op);
      return (op == OP_R_TYPE) || (op == OP_I_TYPE);
   endfunction

endpackage

// File: rtl/mem_stage_lsu.sv
// Memory stage: turns execute results into writeback records, issuing LW/SW
// over a req/gnt/rvalid data port and stalling execute while an access is open.
module mem_stage_lsu
   import mem_stage_lsu_pkg::*;
#(
   parameter int unsigned DSIZE = LSU_DSIZE,
   parameter int unsigned RSIZE = LSU_RSIZE
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             ex_valid,
   output logic             ex_ready,
   input  logic [OP_W-1:0]  ex_op,
   input  logic [DSIZE-1:0] ex_result,
   input  logic [DSIZE-1:0] ex_wdata,
   input  logic [RSIZE-1:0] ex_rd,
   output logic             mem_req,
   output logic             mem_we,
   output logic [DSIZE-1:0] mem_addr,
   output logic [DSIZE-1:0] mem_wdata,
   input  logic             mem_gnt,
   input  logic             mem_rvalid,
   input  logic [DSIZE-1:0] mem_rdata,
   output logic             wb_valid,
   output logic             wb_we,
   output logic [RSIZE-1:0] wb_rd,
   output logic [DSIZE-1:0] wb_data,
   output logic             misalign
);

   lsu_state_e       state_q, state_d;
   logic [RSIZE-1:0] rd_q;
   logic             accept;
   logic             mem_op;
   logic             aligned;
   logic             gnt_hit;
   logic             rsp_hit;

   assign ex_ready = (state_q == LSU_IDLE);

   // Next-state and handshake qualifiers
   always_comb begin
      state_d = state_q;
      accept  = 1'b0;
      gnt_hit = 1'b0;
      rsp_hit = 1'b0;
      mem_op  = is_mem_op(ex_op);
      aligned = (ex_result[1:0] == 2'b00);
      case (state_q)
         LSU_IDLE: begin
            accept = ex_valid;
            if (ex_valid && mem_op && aligned) state_d = LSU_REQ;
         end
         LSU_REQ: begin
            gnt_hit = mem_gnt;
            if (mem_gnt) state_d = mem_we ? LSU_IDLE : LSU_WAIT;
         end
         LSU_WAIT: begin
            rsp_hit = mem_rvalid;
            if (mem_rvalid) state_d = LSU_IDLE;
         end
         default: state_d = LSU_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) state_q <= LSU_IDLE;
      else      state_q <= state_d;
   end

   // Memory command register: latched on accept, held stable until granted
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         mem_req   <= 1'b0;
         mem_we    <= 1'b0;
         mem_addr  <= '0;
         mem_wdata <= '0;
         rd_q      <= '0;
      end else if (accept && mem_op && aligned) begin
         mem_req   <= 1'b1;
         mem_we    <= (ex_op == OP_SW);
         mem_addr  <= ex_result;
         mem_wdata <= ex_wdata;
         rd_q      <= ex_rd;
      end else if (gnt_hit) begin
         mem_req   <= 1'b0;
      end
   end

   // Writeback record: valid and misalign are single-cycle pulses
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         wb_valid <= 1'b0;
         wb_we    <= 1'b0;
         wb_rd    <= '0;
         wb_data  <= '0;
         misalign <= 1'b0;
      end else begin
         wb_valid <= 1'b0;
         wb_we    <= 1'b0;
         misalign <= 1'b0;
         if (accept && !(mem_op && aligned)) begin
            wb_valid <= 1'b1;
            wb_rd    <= ex_rd;
            wb_data  <= ex_result;
            misalign <= mem_op;
            wb_we    <= is_rf_write(ex_op);
         end else if (gnt_hit && mem_we) begin
            wb_valid <= 1'b1;
            wb_rd    <= rd_q;
         end else if (rsp_hit) begin
            wb_valid <= 1'b1;
            wb_we    <= 1'b1;
            wb_rd    <= rd_q;
            wb_data  <= mem_rdata;
         end
      end
   end

endmodule

// File: tb/tb_mem_stage_lsu.sv
// Directed bench for mem_stage_lsu: transaction-level model with a per-cycle
// compare process, plus literal expectations for the headline cases.
module tb_mem_stage_lsu;
   import mem_stage_lsu_pkg::*;

   logic        clk;
   logic        rst;
   logic        ex_valid;
   logic        ex_ready;
   logic [6:0]  ex_op;
   logic [31:0] ex_result;
   logic [31:0] ex_wdata;
   logic [4:0]  ex_rd;
   logic        mem_req;
   logic        mem_we;
   logic [31:0] mem_addr;
   logic [31:0] mem_wdata;
   logic        mem_gnt;
   logic        mem_rvalid;
   logic [31:0] mem_rdata;
   logic        wb_valid;
   logic        wb_we;
   logic [4:0]  wb_rd;
   logic [31:0] wb_data;
   logic        misalign;

   mem_stage_lsu dut (
      .clk(clk), .rst(rst),
      .ex_valid(ex_valid), .ex_ready(ex_ready), .ex_op(ex_op),
      .ex_result(ex_result), .ex_wdata(ex_wdata), .ex_rd(ex_rd),
      .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
      .mem_gnt(mem_gnt), .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata),
      .wb_valid(wb_valid), .wb_we(wb_we), .wb_rd(wb_rd), .wb_data(wb_data),
      .misalign(misalign)
   );

   typedef struct {
      int          due;
      logic        we;
      logic        mis;
      logic [4:0]  rd;
      logic [31:0] data;
   } exp_t;

   exp_t        expq[$];
   int          cyc;
   int          nchk;
   int          nerr;
   logic        exp_busy;
   logic        exp_req;
   logic        exp_we;
   logic [31:0] exp_addr;
   logic [31:0] exp_wdata;

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
      nchk++;
      if (act !== req) begin
         nerr++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, req, cyc);
      end
   endtask

   // What the architecture says an instruction must write back
   function automatic exp_t model(input logic [6:0] op, input logic [31:0] res,
                                  input logic [4:0] rd, input logic [31:0] rdata);
      exp_t e;
      e.due  = 0;
      e.rd   = rd;
      e.data = res;
      e.we   = 1'b0;
      e.mis  = 1'b0;
      if ((op == OP_LW || op == OP_SW) && res[1:0] != 2'b00) e.mis = 1'b1;
      else if (op == OP_LW) begin
         e.we   = 1'b1;
         e.data = rdata;
      end else if (op == OP_R_TYPE || op == OP_I_TYPE) e.we = 1'b1;
      return e;
   endfunction

   always @(negedge clk) begin
      if (!rst) begin
         chk("rst_ex_ready", 32'(ex_ready), 32'd1);
         chk("rst_mem_req", 32'(mem_req), 32'd0);
         chk("rst_mem_we", 32'(mem_we), 32'd0);
         chk("rst_mem_addr", mem_addr, 32'd0);
         chk("rst_mem_wdata", mem_wdata, 32'd0);
         chk("rst_wb_valid", 32'(wb_valid), 32'd0);
         chk("rst_wb_we", 32'(wb_we), 32'd0);
         chk("rst_wb_rd", 32'(wb_rd), 32'd0);
         chk("rst_wb_data", wb_data, 32'd0);
         chk("rst_misalign", 32'(misalign), 32'd0);
      end else begin
         chk("ex_ready", 32'(ex_ready), 32'(!exp_busy));
         chk("mem_req", 32'(mem_req), 32'(exp_req));
         if (mem_req) begin
            chk("mem_we", 32'(mem_we), 32'(exp_we));
            chk("mem_addr", mem_addr, exp_addr);
            chk("mem_wdata", mem_wdata, exp_wdata);
         end
         if (wb_valid) begin
            if (expq.size() == 0) chk("wb_valid_unexpected", 32'(wb_valid), 32'd0);
            else begin
               exp_t e;
               e = expq.pop_front();
               chk("wb_cycle", 32'(cyc), 32'(e.due));
               chk("wb_we", 32'(wb_we), 32'(e.we));
               chk("misalign", 32'(misalign), 32'(e.mis));
               if (e.we) begin
                  chk("wb_rd", 32'(wb_rd), 32'(e.rd));
                  chk("wb_data", wb_data, e.data);
               end
            end
         end else begin
            chk("misalign_idle", 32'(misalign), 32'd0);
            if (expq.size() > 0 && expq[0].due <= cyc) begin
               chk("wb_valid_missing", 32'(wb_valid), 32'd1);
               void'(expq.pop_front());
            end
         end
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Present one instruction and play the memory side with the given delays
   task automatic issue(input logic [6:0] op, input logic [31:0] res, input logic [31:0] wd,
                        input logic [4:0] rd, input int gd, input int rvd, input logic [31:0] rdata);
      exp_t e;
      logic memop;
      memop = (op == OP_LW || op == OP_SW);
      e = model(op, res, rd, rdata);
      ex_valid  = 1'b1;
      ex_op     = op;
      ex_result = res;
      ex_wdata  = wd;
      ex_rd     = rd;
      if (!memop || res[1:0] != 2'b00) begin
         e.due = cyc + 1;
         expq.push_back(e);
         tick();
         ex_valid = 1'b0;
      end else begin
         exp_we    = (op == OP_SW);
         exp_addr  = res;
         exp_wdata = wd;
         tick();
         exp_busy = 1'b1;
         exp_req  = 1'b1;
         // upstream keeps offering work and a stray response appears while in REQ
         ex_valid   = 1'b1;
         ex_op      = OP_R_TYPE;
         ex_result  = ~res;
         ex_rd      = 5'd31;
         mem_rvalid = 1'b1;
         mem_rdata  = 32'hBAD0_BAD0;
         for (int k = 0; k < gd; k++) tick();
         ex_valid   = 1'b0;
         mem_rvalid = 1'b0;
         mem_gnt    = 1'b1;
         if (op == OP_SW) begin
            e.due = cyc + 1;
            expq.push_back(e);
            tick();
            mem_gnt  = 1'b0;
            exp_req  = 1'b0;
            exp_busy = 1'b0;
         end else begin
            tick();
            exp_req  = 1'b0;
            ex_valid = 1'b1;
            for (int k = 0; k < rvd; k++) tick();
            ex_valid   = 1'b0;
            mem_gnt    = 1'b0;
            mem_rvalid = 1'b1;
            mem_rdata  = rdata;
            e.due = cyc + 1;
            expq.push_back(e);
            tick();
            mem_rvalid = 1'b0;
            mem_rdata  = 32'h0;
            exp_busy   = 1'b0;
         end
      end
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
      $fatal(1, "watchdog");
   end

   initial begin
      nchk = 0;
      nerr = 0;
      exp_busy = 1'b0;
      exp_req = 1'b0;
      exp_we = 1'b0;
      exp_addr = 32'h0;
      exp_wdata = 32'h0;
      rst = 1'b0;
      ex_valid = 1'b0;
      ex_op = 7'h0;
      ex_result = 32'h0;
      ex_wdata = 32'h0;
      ex_rd = 5'd0;
      mem_gnt = 1'b0;
      mem_rvalid = 1'b0;
      mem_rdata = 32'h0;
      repeat (2) tick();
      rst = 1'b1;
      tick();

      // ADD x3 = 5: record one cycle later
      issue(OP_R_TYPE, 32'h0000_0005, 32'h0, 5'd3, 0, 0, 32'h0);
      @(negedge clk);
      chk("add_wb_valid", 32'(wb_valid), 32'd1);
      chk("add_wb_we", 32'(wb_we), 32'd1);
      chk("add_wb_rd", 32'(wb_rd), 32'd3);
      chk("add_wb_data", wb_data, 32'h5);
      tick();

      // SW to 0x10 with grant two cycles late
      issue(OP_SW, 32'h10, 32'hDEAD_BEEF, 5'd9, 2, 0, 32'h0);
      @(negedge clk);
      chk("sw_wb_valid", 32'(wb_valid), 32'd1);
      chk("sw_wb_we", 32'(wb_we), 32'd0);
      tick();

      // LW from 0x20, immediate grant, data three cycles after grant
      issue(OP_LW, 32'h20, 32'h0, 5'd7, 0, 2, 32'h1234_5678);
      @(negedge clk);
      chk("lw_wb_data", wb_data, 32'h1234_5678);
      chk("lw_wb_rd", 32'(wb_rd), 32'd7);
      chk("lw_wb_we", 32'(wb_we), 32'd1);
      tick();

      // Misaligned load and store: no memory traffic
      issue(OP_LW, 32'h22, 32'h0, 5'd4, 0, 0, 32'h0);
      @(negedge clk);
      chk("mis_lw_flag", 32'(misalign), 32'd1);
      chk("mis_lw_we", 32'(wb_we), 32'd0);
      chk("mis_lw_req", 32'(mem_req), 32'd0);
      tick();
      issue(OP_SW, 32'h13, 32'h5555_AAAA, 5'd2, 0, 0, 32'h0);
      tick();

      // Reset during WAIT, then a stray response after release
      ex_valid = 1'b1; ex_op = OP_LW; ex_result = 32'h40; ex_rd = 5'd4;
      exp_we = 1'b0; exp_addr = 32'h40; exp_wdata = ex_wdata;
      tick();
      ex_valid = 1'b0;
      exp_busy = 1'b1;
      exp_req = 1'b1;
      mem_gnt = 1'b1;
      tick();
      mem_gnt = 1'b0;
      exp_req = 1'b0;
      tick();
      rst = 1'b0;
      exp_busy = 1'b0;
      tick();
      rst = 1'b1;
      mem_rvalid = 1'b1;
      mem_rdata = 32'hFEED_FACE;
      @(negedge clk);
      chk("post_rst_ex_ready", 32'(ex_ready), 32'd1);
      tick();
      mem_rvalid = 1'b0;
      repeat (2) tick();

      // Three ADDI x3 and a BNE back to back
      issue(OP_I_TYPE, 32'h0000_0001, 32'h0, 5'd3, 0, 0, 32'h0);
      issue(OP_I_TYPE, 32'h0000_0002, 32'h0, 5'd3, 0, 0, 32'h0);
      issue(OP_I_TYPE, 32'h0000_0003, 32'h0, 5'd3, 0, 0, 32'h0);
      issue(OP_COND_BRANCH, 32'h0000_0100, 32'h0, 5'd0, 0, 0, 32'h0);
      @(negedge clk);
      chk("bne_wb_valid", 32'(wb_valid), 32'd1);
      chk("bne_wb_we", 32'(wb_we), 32'd0);
      tick();

      // Unknown opcode, load to x0, minimum-latency store, stray handshakes while idle
      issue(7'h7F, 32'h77, 32'h0, 5'd6, 0, 0, 32'h0);
      issue(OP_LW, 32'h30, 32'h0, 5'd0, 0, 0, 32'hCAFE_F00D);
      issue(OP_SW, 32'h44, 32'h0BAD_CAFE, 5'd1, 0, 0, 32'h0);
      mem_gnt = 1'b1;
      mem_rvalid = 1'b1;
      mem_rdata = 32'h1111_2222;
      repeat (2) tick();
      mem_gnt = 1'b0;
      mem_rvalid = 1'b0;
      issue(OP_R_TYPE, 32'hFFFF_FFFF, 32'h0, 5'd31, 0, 0, 32'h0);
      repeat (3) tick();

      chk("expected_records_left", 32'(expq.size()), 32'd0);
      $display("Result: errors=%0d of %0d checks", nerr, nchk);
      $finish;
   end

endmodule
